sopc_2_pio_poller: RTL

//  Avalon-MM master that periodically reads the data register (offset 0) of an 8-bit input PIO slave.
//  - Filters the sampled value, publishes it and flags changes to local logic with a strobe and a sticky IRQ.
//  - Sits beside the PIO input slaves in sopc_2. Lets hardware consume input-port state without CPU polling.

---
 rtl/sopc_2_poll_pkg.sv | 16 +
 rtl/sopc_2_poll_timer.sv | 29 ++
 rtl/sopc_2_pio_poller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sopc_2_poll_pkg.sv
// Shared encodings and width helpers for the sopc_2 PIO poller.
package sopc_2_poll_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    // Read latency is 1..4, so the remaining-latency count never exceeds 3.
    localparam int LAT_W = 2;

    function automatic int timer_w(input int period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/sopc_2_poll_timer.sv
// Poll-period down-counter: emits a one-cycle tick every PERIOD enabled cycles,
// holding its count while enable is low.
module sopc_2_poll_timer
    import sopc_2_poll_pkg::*;
#(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int TW = timer_w(PERIOD);
    localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RELOAD;
        end else if (enable) begin
            count <= (count == '0) ? RELOAD : count - TW'(1);
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/sopc_2_pio_poller.sv
// Avalon-MM master that periodically reads a PIO data register and publishes changes.
// Define POLL_DEBOUNCE_EN to require two consecutive equal reads before publishing.
module sopc_2_pio_poller
    import sopc_2_poll_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int POLL_ADDR = 0,
    parameter int PERIOD    = 1000,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    output logic              change_irq,
    input  logic              irq_ack
);

    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] sample;
    logic              tick;
    logic              pending;
    logic              go_req;
    logic              seen_first;
    logic              candidate;
    logic              capture_now;
    logic              do_publish;
    logic              set_irq;

    sopc_2_poll_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    always_comb begin
        next_state = state;
        go_req     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (tick || pending)) begin
                    go_req     = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == '0) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // A tick that arrived mid-transaction starts the next read straight away.
                if (enable && (tick || pending)) begin
                    go_req     = 1'b1;
                    next_state = ST_REQ;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign capture_now = (state == ST_WAIT) && (lat_cnt == '0);
    assign do_publish  = (state == ST_CAPTURE) && candidate && ((sample != value) || !seen_first);
    assign set_irq     = do_publish && seen_first;

`ifdef POLL_DEBOUNCE_EN
    logic [DATA_W-1:0] raw;
    logic              raw_seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw      <= '0;
            raw_seen <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            raw      <= sample;
            raw_seen <= 1'b1;
        end
    end

    assign candidate = raw_seen && (sample == raw);
`else
    assign candidate = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            sample      <= '0;
            pending     <= 1'b0;
            seen_first  <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            change_irq  <= 1'b0;
        end else begin
            state <= next_state;

            if (go_req) pending <= 1'b0;
            else if (tick) pending <= 1'b1;

            if ((state == ST_REQ) && !avm_waitrequest) lat_cnt <= LAT_RELOAD;
            else if ((state == ST_WAIT) && (lat_cnt != '0)) lat_cnt <= lat_cnt - LAT_W'(1);

            if (capture_now) sample <= avm_readdata[DATA_W-1:0];

            value_valid <= do_publish;
            if (do_publish) begin
                value      <= sample;
                seen_first <= 1'b1;
            end

            // A new change outranks an acknowledge landing in the same cycle.
            if (set_irq) change_irq <= 1'b1;
            else if (irq_ack) change_irq <= 1'b0;
        end
    end

    assign avm_read    = (state == ST_REQ);
    assign avm_address = ADDR_W'(POLL_ADDR);

    generate
        if (DATA_W < 32) begin : g_unused
            logic unused_readdata;
            assign unused_readdata = ^avm_readdata[31:DATA_W];
        end
    endgenerate

endmodule
